// File: rtl/alu_sequencer.sv
// Sequential front-end for the combinational alu: latches a job on start, drives the ALU,
// waits a settle interval, captures the result and streams captures out on valid/ready.
module alu_sequencer #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [3:0]   sel_in,
    input  logic         sweep,
    output logic         busy,
    output logic         err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_sel,
    output logic [N-1:0] out_result,
    output logic         out_carry,
    output logic         out_zero,
    output logic         out_last,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_op_sum,
    output logic         alu_op_subt,
    input  logic [N-1:0] alu_result,
    input  logic         alu_carry_sum,
    input  logic         alu_carry_subt
);

    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, OUT = 2'd2} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] SWEEP_LAST  = 4'd9;

    // Sweep order is add, subtract, then the eight op codes.
    function automatic logic [3:0] idx_to_sel(input logic [3:0] idx);
        case (idx)
            4'd0:    idx_to_sel = 4'd8;
            4'd1:    idx_to_sel = 4'd9;
            default: idx_to_sel = idx - 4'd2;
        endcase
    endfunction

    // Returns {alu_op, alu_op_sum, alu_op_subt} for an operation select.
    function automatic logic [4:0] sel_to_drive(input logic [3:0] sel);
        case (sel)
            4'd8:    sel_to_drive = {3'd0, 1'b1, 1'b0};
            4'd9:    sel_to_drive = {3'd0, 1'b0, 1'b1};
            default: sel_to_drive = {sel[2:0], 1'b0, 1'b0};
        endcase
    endfunction

    state_t         state_r, state_s;
    logic [N-1:0]   a_r, a_s, b_r, b_s;
    logic [2:0]     op_r, op_s;
    logic           op_sum_r, op_sum_s, op_subt_r, op_subt_s;
    logic [3:0]     sel_r, sel_s, idx_r, idx_s, cnt_r, cnt_s;
    logic           sweep_r, sweep_s, busy_r, busy_s, err_r, err_s;
    logic           valid_r, valid_s, carry_r, carry_s, zero_r, zero_s, last_r, last_s;
    logic [3:0]     osel_r, osel_s;
    logic [N-1:0]   res_r, res_s;
    logic [3:0]     nsel_s;

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        a_s       = a_r;
        b_s       = b_r;
        op_s      = op_r;
        op_sum_s  = op_sum_r;
        op_subt_s = op_subt_r;
        sel_s     = sel_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        sweep_s   = sweep_r;
        busy_s    = busy_r;
        err_s     = 1'b0;
        valid_s   = valid_r;
        osel_s    = osel_r;
        res_s     = res_r;
        carry_s   = carry_r;
        zero_s    = zero_r;
        last_s    = last_r;
        nsel_s    = 4'd0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (!sweep && (sel_in >= 4'd10)) begin
                        err_s = 1'b1;
                    end else begin
                        nsel_s  = sweep ? 4'd8 : sel_in;
                        a_s     = a_in;
                        b_s     = b_in;
                        sweep_s = sweep;
                        sel_s   = nsel_s;
                        {op_s, op_sum_s, op_subt_s} = sel_to_drive(nsel_s);
                        idx_s   = 4'd0;
                        cnt_s   = 4'd0;
                        busy_s  = 1'b1;
                        state_s = DRIVE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_r == SETTLE_LAST) begin
                    valid_s = 1'b1;
                    osel_s  = sel_r;
                    res_s   = alu_result;
                    zero_s  = (alu_result == {N{1'b0}});
                    carry_s = (sel_r == 4'd8) ? alu_carry_sum :
                              (sel_r == 4'd9) ? alu_carry_subt : 1'b0;
                    last_s  = !sweep_r || (idx_r == SWEEP_LAST);
                    state_s = OUT;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    valid_s = 1'b0;
                    if (sweep_r && (idx_r != SWEEP_LAST)) begin
                        nsel_s  = idx_to_sel(idx_r + 4'd1);
                        idx_s   = idx_r + 4'd1;
                        sel_s   = nsel_s;
                        {op_s, op_sum_s, op_subt_s} = sel_to_drive(nsel_s);
                        cnt_s   = 4'd0;
                        state_s = DRIVE;
                    end else begin
                        op_s      = 3'd0;
                        op_sum_s  = 1'b0;
                        op_subt_s = 1'b0;
                        busy_s    = 1'b0;
                        state_s   = IDLE;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= {N{1'b0}};
            b_r       <= {N{1'b0}};
            op_r      <= 3'd0;
            op_sum_r  <= 1'b0;
            op_subt_r <= 1'b0;
            sel_r     <= 4'd0;
            idx_r     <= 4'd0;
            cnt_r     <= 4'd0;
            sweep_r   <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            valid_r   <= 1'b0;
            osel_r    <= 4'd0;
            res_r     <= {N{1'b0}};
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            b_r       <= b_s;
            op_r      <= op_s;
            op_sum_r  <= op_sum_s;
            op_subt_r <= op_subt_s;
            sel_r     <= sel_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            sweep_r   <= sweep_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
            valid_r   <= valid_s;
            osel_r    <= osel_s;
            res_r     <= res_s;
            carry_r   <= carry_s;
            zero_r    <= zero_s;
            last_r    <= last_s;
        end
    end

    assign busy        = busy_r;
    assign err         = err_r;
    assign out_valid   = valid_r;
    assign out_sel     = osel_r;
    assign out_result  = res_r;
    assign out_carry   = carry_r;
    assign out_zero    = zero_r;
    assign out_last    = last_r;
    assign alu_a       = a_r;
    assign alu_b       = b_r;
    assign alu_op      = op_r;
    assign alu_op_sum  = op_sum_r;
    assign alu_op_subt = op_subt_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural stand-in for the alu.
module tb_alu_sequencer;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_in = 4'd0, b_in = 4'd0, sel_in = 4'd0;
    logic       sweep = 1'b0, out_ready = 1'b1;
    logic       busy, err, out_valid, out_carry, out_zero, out_last;
    logic [3:0] out_sel, out_result, alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_op_sum, alu_op_subt, alu_carry_sum, alu_carry_subt;

    int errors = 0;
    int checks = 0;
    exp_t q[$];
    exp_t last_exp;
    logic [3:0] pat [8];
    logic [3:0] order [10];

    alu_sequencer #(.N(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .sel_in(sel_in), .sweep(sweep), .busy(busy), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
        .out_last(out_last), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_op_sum(alu_op_sum), .alu_op_subt(alu_op_subt),
        .alu_result(alu_result), .alu_carry_sum(alu_carry_sum),
        .alu_carry_subt(alu_carry_subt)
    );

    always #5 clk = ~clk;

    initial begin
        pat   = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0111, 4'b1110};
        order = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    end

    // Stand-in for the combinational alu.
    always_comb begin
        alu_carry_sum  = ({1'b0, alu_a} + {1'b0, alu_b}) > 5'd15;
        alu_carry_subt = (alu_a >= alu_b);
        if (alu_op_sum)       alu_result = alu_a + alu_b;
        else if (alu_op_subt) alu_result = alu_a - alu_b;
        else                  alu_result = pat[alu_op];
    end

    function automatic exp_t model(input logic [3:0] s, input logic [3:0] a,
                                   input logic [3:0] b, input logic l);
        exp_t e;
        logic [4:0] t;
        e.sel = s;
        e.l   = l;
        if (s == 4'd8) begin
            t = {1'b0, a} + {1'b0, b};
            e.res = t[3:0];
            e.c = t[4];
        end else if (s == 4'd9) begin
            t = {1'b0, a} + {1'b0, ~b} + 5'd1;
            e.res = t[3:0];
            e.c = t[4];
        end else begin
            e.res = pat[s[2:0]];
            e.c = 1'b0;
        end
        e.z = (e.res == 4'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push_job(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] s, input logic sw);
        if (sw) begin
            for (int i = 0; i < 10; i++) q.push_back(model(order[i], a, b, i == 9));
        end else begin
            q.push_back(model(s, a, b, 1'b1));
        end
    endtask

    task automatic do_start(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] s, input logic sw);
        @(negedge clk);
        a_in = a; b_in = b; sel_in = s; sweep = sw; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for out_valid on a falling edge and compares against the scoreboard head.
    task automatic wait_capture(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 50);
        check("capture_timeout", 32'(out_valid), 32'd1);
        check("queue_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) last_exp = q.pop_front();
        check("out_sel", 32'(out_sel), 32'(last_exp.sel));
        check("out_result", 32'(out_result), 32'(last_exp.res));
        check("out_carry", 32'(out_carry), 32'(last_exp.c));
        check("out_zero", 32'(out_zero), 32'(last_exp.z));
        check("out_last", 32'(out_last), 32'(last_exp.l));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_outs"}, {22'd0, out_sel, out_result, out_carry, out_zero}, 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_alu"}, {19'd0, alu_a, alu_b, alu_op, alu_op_sum, alu_op_subt}, 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;

        // Reset state
        #2 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single add: 9 + 8 wraps to 1 with carry
        push_job(4'd9, 4'd8, 4'd8, 1'b0);
        do_start(4'd9, 4'd8, 4'd8, 1'b0);
        wait_capture(cyc);
        check("add_latency", 32'(cyc), 32'd2);
        @(negedge clk);
        check("add_busy_drop", 32'(busy), 32'd0);
        check("add_valid_drop", 32'(out_valid), 32'd0);
        check("add_idle_sum", 32'(alu_op_sum), 32'd0);

        // Single subtract: 5 - 5 = 0
        push_job(4'd5, 4'd5, 4'd9, 1'b0);
        do_start(4'd5, 4'd5, 4'd9, 1'b0);
        wait_capture(cyc);
        check("sub_latency", 32'(cyc), 32'd2);
        @(negedge clk);
        check("sub_busy_drop", 32'(busy), 32'd0);

        // Full sweep, consumer always ready
        push_job(4'd3, 4'd1, 4'd0, 1'b1);
        do_start(4'd3, 4'd1, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            wait_capture(cyc);
            check("sweep_rate", 32'(cyc), 32'd2);
        end
        @(negedge clk);
        check("sweep_busy_drop", 32'(busy), 32'd0);

        // Sweep with backpressure on the 2nd capture
        push_job(4'd6, 4'd2, 4'd0, 1'b1);
        do_start(4'd6, 4'd2, 4'd0, 1'b1);
        wait_capture(cyc);
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_capture(cyc);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                a_in = 4'hF; b_in = 4'hF; sel_in = 4'd12; sweep = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sel", 32'(out_sel), 32'(last_exp.sel));
            check("stall_result", 32'(out_result), 32'(last_exp.res));
            check("stall_carry", 32'(out_carry), 32'(last_exp.c));
            check("stall_alu", {21'd0, alu_a, alu_b, alu_op_subt}, {21'd0, 4'd6, 4'd2, 1'b1});
            check("stall_err", 32'(err), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            wait_capture(cyc);
            check("resume_rate", 32'(cyc), 32'd2);
        end
        @(negedge clk);
        check("bp_busy_drop", 32'(busy), 32'd0);

        // Invalid select in single mode
        do_start(4'd7, 4'd7, 4'd12, 1'b0);
        @(negedge clk);
        check("inv_err", 32'(err), 32'd1);
        check("inv_busy", 32'(busy), 32'd0);
        check("inv_ops", {30'd0, alu_op_sum, alu_op_subt}, 32'd0);
        @(negedge clk);
        check("inv_err_pulse", 32'(err), 32'd0);
        check("inv_valid", 32'(out_valid), 32'd0);

        // Reset during the 4th DRIVE of a sweep
        push_job(4'd3, 4'd1, 4'd0, 1'b1);
        do_start(4'd3, 4'd1, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) wait_capture(cyc);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
